// File: rtl/bsg_dlatch_wr_pkg.sv
// bsg_dlatch_wr_pkg
// Shared definitions for the latch-array write controller:
//   - wr_state_e     : 2-bit FSM state encoding (IDLE, SETUP, OPEN, HOLD)
//   - wr_period_lp   : cycles taken by one complete write (peak throughput)
//   - parity_bits_lp : extra data_o bits added when BSG_DLATCH_WR_PARITY_EN is defined
//   - lg_els()       : address width helper, never smaller than one bit
package bsg_dlatch_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } wr_state_e;

    localparam int wr_period_lp = 4;

`ifdef BSG_DLATCH_WR_PARITY_EN
    localparam int parity_bits_lp = 1;
`else
    localparam int parity_bits_lp = 0;
`endif

    // A single-entry array still needs a one-bit address port.
    function automatic int lg_els(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bsg_dlatch_wr_decode.sv
// bsg_dlatch_wr_decode
// Binary-to-one-hot decoder with range check for the latch write controller.
// Ports:
//   addr         : in  lg_els(els_p) bits, captured entry index
//   one_hot      : out els_p bits, bit addr set when addr is in range
//   out_of_range : out 1 bit, high when addr >= els_p
module bsg_dlatch_wr_decode
    import bsg_dlatch_wr_pkg::*;
#(
    parameter  int els_p     = 8,
    localparam int lg_els_lp = lg_els(els_p)
) (
    input  logic [lg_els_lp-1:0] addr,
    output logic [els_p-1:0]     one_hot,
    output logic                 out_of_range
);

    // An out-of-range index matches no bit position, so the one-hot
    // vector is naturally all-zero in that case.
    always_comb begin
        one_hot      = '0;
        out_of_range = (int'(addr) >= els_p);
        for (int i = 0; i < els_p; i++) begin
            one_hot[i] = (int'(addr) == i);
        end
    end

endmodule

// File: rtl/bsg_dlatch_wr_ctrl.sv
// bsg_dlatch_wr_ctrl
// Write controller for a latch-based storage array. Each accepted write walks
// IDLE -> SETUP -> OPEN -> HOLD -> IDLE, holding data stable around a single
// registered, glitch-free enable pulse in OPEN.
// Optional feature macro: BSG_DLATCH_WR_PARITY_EN (adds an even-parity MSB to data_o).
// Ports:
//   clk_i      : in  clock, rising edge
//   reset_i    : in  synchronous active-high reset
//   v_i        : in  write request valid
//   ready_o    : out write request accepted when v_i & ready_o
//   addr_i     : in  target entry index
//   data_i     : in  write data
//   clear_i    : in  clear all entry-valid flags
//   data_o     : out held write data (plus parity MSB when enabled)
//   latch_en_o : out one-hot latch enables, high only during OPEN
//   entry_v_o  : out per-entry written flags
//   err_o      : out one-cycle pulse in OPEN for an out-of-range address
module bsg_dlatch_wr_ctrl
    import bsg_dlatch_wr_pkg::*;
#(
    parameter  int width_p   = 16,
    parameter  int els_p     = 8,
    localparam int lg_els_lp = lg_els(els_p),
    localparam int data_w_lp = width_p + parity_bits_lp
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 v_i,
    output logic                 ready_o,
    input  logic [lg_els_lp-1:0] addr_i,
    input  logic [width_p-1:0]   data_i,
    input  logic                 clear_i,
    output logic [data_w_lp-1:0] data_o,
    output logic [els_p-1:0]     latch_en_o,
    output logic [els_p-1:0]     entry_v_o,
    output logic                 err_o
);

    wr_state_e              state;
    wr_state_e              state_n;
    logic [lg_els_lp-1:0]   addr_r;
    logic [els_p-1:0]       en_n;
    logic                   oor;
    logic                   handshake;
    logic [data_w_lp-1:0]   data_cap;
    logic [els_p-1:0]       entry_v_n;

    // Requests are only taken in IDLE and never while reset is held.
    assign ready_o   = (state == IDLE) && !reset_i;
    assign handshake = v_i && ready_o;

    // Parity travels with the data so the array can check it on read.
`ifdef BSG_DLATCH_WR_PARITY_EN
    assign data_cap = {^data_i, data_i};
`else
    assign data_cap = data_i;
`endif

    // Only IDLE waits; every other state advances unconditionally.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = handshake ? SETUP : IDLE;
            SETUP:   state_n = OPEN;
            OPEN:    state_n = HOLD;
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The decode looks at the captured address during SETUP so the enable
    // flop can be loaded one cycle ahead of OPEN.
    bsg_dlatch_wr_decode #(
        .els_p (els_p)
    ) decode (
        .addr         (addr_r),
        .one_hot      (en_n),
        .out_of_range (oor)
    );

    // Set wins over clear: the enable bit driven during OPEN marks exactly
    // the entry being written, and is already zero for a bad address.
    always_comb begin
        entry_v_n = clear_i ? '0 : entry_v_o;
        if (state == OPEN) begin
            entry_v_n = entry_v_n | latch_en_o;
        end
    end

    // FSM, capture registers and enable flop. latch_en_o comes straight
    // from a flop so it cannot glitch; a reset in any state drops it and
    // discards the pending write before its entry flag can be set.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            addr_r     <= '0;
            data_o     <= '0;
            latch_en_o <= '0;
            err_o      <= 1'b0;
            entry_v_o  <= '0;
        end else begin
            state <= state_n;
            if (handshake) begin
                addr_r <= addr_i;
                data_o <= data_cap;
            end
            latch_en_o <= (state == SETUP) ? en_n : '0;
            err_o      <= (state == SETUP) && oor;
            entry_v_o  <= entry_v_n;
        end
    end

endmodule

// File: tb/tb_bsg_dlatch_wr_ctrl.sv
// tb_bsg_dlatch_wr_ctrl
// Bench for bsg_dlatch_wr_ctrl. Two instances share every input: one with
// els_p=8 and one with els_p=5 so out-of-range addresses can be exercised.
// A cycle-level model tracks each write by the number of cycles since it
// was accepted and predicts every output of both instances.
module tb_bsg_dlatch_wr_ctrl;

`ifdef BSG_DLATCH_WR_PARITY_EN
    localparam int dw = 17;
`else
    localparam int dw = 16;
`endif

    logic          clk;
    logic          reset_i;
    logic          v_i;
    logic [2:0]    addr_i;
    logic [15:0]   data_i;
    logic          clear_i;

    logic          ready8, ready5;
    logic [dw-1:0] data8, data5;
    logic [7:0]    en8, ev8;
    logic [4:0]    en5, ev5;
    logic          err8, err5;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            age;
    int            cap_addr;
    logic [dw-1:0] m_data;
    logic [7:0]    m_ev8;
    logic [4:0]    m_ev5;

    bsg_dlatch_wr_ctrl #(.width_p(16), .els_p(8)) dut8 (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .ready_o    (ready8),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .clear_i    (clear_i),
        .data_o     (data8),
        .latch_en_o (en8),
        .entry_v_o  (ev8),
        .err_o      (err8)
    );

    bsg_dlatch_wr_ctrl #(.width_p(16), .els_p(5)) dut5 (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .ready_o    (ready5),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .clear_i    (clear_i),
        .data_o     (data5),
        .latch_en_o (en5),
        .entry_v_o  (ev5),
        .err_o      (err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [dw-1:0] expect_data(input logic [15:0] d);
`ifdef BSG_DLATCH_WR_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // One clock cycle: drive inputs, check ready, advance the model at the
    // edge and check every registered output just after it.
    task automatic apply_stimulus(input logic v, input int a, input logic [15:0] d,
                                  input logic clr, input logic rst);
        logic [31:0] want_en8, want_en5;
        v_i     = v;
        addr_i  = a[2:0];
        data_i  = d;
        clear_i = clr;
        reset_i = rst;
        #1;
        check_output("ready8", ready8, 32'((age == 0) && !rst));
        check_output("ready5", ready5, 32'((age == 0) && !rst));
        @(posedge clk);
        if (rst) begin
            age    = 0;
            m_data = '0;
            m_ev8  = '0;
            m_ev5  = '0;
        end else begin
            if (clr) begin
                m_ev8 = '0;
                m_ev5 = '0;
            end
            if (age == 2) begin
                if (cap_addr < 8) m_ev8[cap_addr] = 1'b1;
                if (cap_addr < 5) m_ev5[cap_addr] = 1'b1;
            end
            if (age == 0) begin
                if (v) begin
                    age      = 1;
                    cap_addr = a;
                    m_data   = expect_data(d);
                end
            end else begin
                age = (age + 1) % 4;
            end
        end
        want_en8 = (age == 2 && cap_addr < 8) ? (32'd1 << cap_addr) : 32'd0;
        want_en5 = (age == 2 && cap_addr < 5) ? (32'd1 << cap_addr) : 32'd0;
        #1;
        check_output("data8", 32'(data8), 32'(m_data));
        check_output("data5", 32'(data5), 32'(m_data));
        check_output("en8", 32'(en8), want_en8);
        check_output("en5", 32'(en5), want_en5);
        check_output("ev8", 32'(ev8), 32'(m_ev8));
        check_output("ev5", 32'(ev5), 32'(m_ev5));
        check_output("err8", 32'(err8), 32'(age == 2 && cap_addr >= 8));
        check_output("err5", 32'(err5), 32'(age == 2 && cap_addr >= 5));
    endtask

    // A full four-cycle write, optionally pulsing clear during OPEN.
    task automatic do_write(input int a, input logic [15:0] d, input logic clr_open);
        apply_stimulus(1'b1, a, d, 1'b0, 1'b0);
        apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 0, 16'h0, clr_open, 1'b0);
        apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        age      = 0;
        cap_addr = 0;
        m_data   = '0;
        m_ev8    = '0;
        m_ev5    = '0;
        v_i      = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        clear_i  = 1'b0;
        reset_i  = 1'b1;

        // Reset state
        apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b1);

        // Single write to entry 3
        do_write(3, 16'hA5C3, 1'b0);
        check_output("single_ev8", 32'(ev8), 32'h08);

        // v_i held high: accepts every fourth cycle only
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, i / 4, 16'($urandom), 1'b0, 1'b0);
        end
        apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b0);

        // Out-of-range for the five-entry instance
        do_write(6, 16'h1234, 1'b0);

        // Build entry_v = 0F then clear coinciding with OPEN of a write to 5
        apply_stimulus(1'b0, 0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_write(i, 16'($urandom), 1'b0);
        end
        check_output("ev_before_clear", 32'(ev8), 32'h0F);
        do_write(5, 16'hBEEF, 1'b1);
        check_output("set_wins_ev8", 32'(ev8), 32'h20);

        // Reset in SETUP aborts the write
        apply_stimulus(1'b1, 2, 16'h5555, 1'b0, 1'b0);
        apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b0);

        // Parity corner values
        do_write(1, 16'h0001, 1'b0);
        do_write(2, 16'h0003, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom % 4) != 0, int'($urandom % 8), 16'($urandom),
                           ($urandom % 8) == 0, ($urandom % 40) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_dlatch_wr_ctrl.md
BSG_DLATCH_WR_CTRL -- requirements
Module: bsg_dlatch_wr_ctrl

Interface
REQ-001 Parameter: width_p, default 16, data bits per latch entry.
REQ-002 Parameter: els_p, default 8, number of latch entries driven; lg_els_lp = max(1, clog2(els_p)).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 v_i  input  1  write request valid.
REQ-006 ready_o  output  1  write request accepted when v_i & ready_o at clock edge.
REQ-007 addr_i  input  lg_els_lp  target entry index.
REQ-008 data_i  input  width_p  write data.
REQ-009 clear_i  input  1  clear all entry-valid flags.
REQ-010 data_o  output  width_p (+1 with parity)  held write data to latch-array data inputs.
REQ-011 latch_en_o  output  els_p  one-hot latch enables, registered, glitch-free.
REQ-012 entry_v_o  output  els_p  per-entry written flags.
REQ-013 err_o  output  1  single-cycle pulse for out-of-range address.

Function
REQ-014 The block SHALL implement FSM states IDLE, SETUP, OPEN, HOLD with transitions IDLE->SETUP on handshake, SETUP->OPEN, OPEN->HOLD, HOLD->IDLE unconditionally.
REQ-015 ready_o SHALL be 1 only in IDLE with reset_i low; there is no acceptance in any other state.
REQ-016 On handshake at edge ending cycle N, addr_i/data_i SHALL be captured; SETUP in N+1, OPEN in N+2, HOLD in N+3, IDLE and ready_o=1 in N+4.
REQ-017 Peak throughput SHALL be one write per 4 cycles; back-to-back v_i held high accepts at cycles N, N+4, N+8.
REQ-018 data_o SHALL equal the captured data throughout SETUP, OPEN, HOLD and retain its last value in IDLE.
REQ-019 latch_en_o SHALL be all-zero except during OPEN, where exactly bit addr is 1, driven directly from a flop.
REQ-020 Addresses >= els_p SHALL assert no latch_en_o bit, leave entry_v_o unchanged, pulse err_o for the OPEN cycle, and still traverse all FSM states.
REQ-021 entry_v_o[addr] SHALL set at the edge ending a valid OPEN cycle.
REQ-022 clear_i SHALL zero entry_v_o at the next edge; when clear_i coincides with OPEN, the result SHALL be only the written bit set (set wins over clear).
REQ-023 clear_i SHALL NOT affect the FSM, data_o or latch_en_o.

Reset
REQ-024 While reset_i is high at an edge: state->IDLE, latch_en_o=0, data_o=0, entry_v_o=0, err_o=0.
REQ-025 ready_o SHALL be 0 while reset_i is high and 1 in the first cycle after its deassertion.
REQ-026 Reset asserted mid-operation (SETUP/OPEN/HOLD) SHALL abort the write, and latch_en_o SHALL be 0 from the next cycle, with no partial entry_v_o update.

Configuration
REQ-027 Macro BSG_DLATCH_WR_PARITY_EN defined: data_o is width_p+1 bits, MSB = even parity (XOR) of the captured data, registered with the data.
REQ-028 Macro BSG_DLATCH_WR_PARITY_EN undefined: data_o is exactly width_p bits, and no parity logic is present.

Structure
REQ-029 Package bsg_dlatch_wr_pkg SHALL hold the FSM state enum typedef (2 bits) and the 4-cycle write-period constant.
REQ-030 One sub-module, bsg_dlatch_wr_decode (binary-to-one-hot with range check, els_p parameter), SHALL produce the next-cycle enable vector and the out-of-range flag.

Verification
REQ-031 Reset release then v_i=1, addr=3, data=16'hA5C3 at cycle 0 -> data_o=A5C3 cycles 1-3; latch_en_o=8'h08 only in cycle 2; entry_v_o[3]=1 from cycle 3; ready_o=1 in cycle 4.
REQ-032 v_i held high with addr 0,1,2 -> accepts at cycles 0,4,8 only; latch_en_o = 01,02,04 in cycles 2,6,10.
REQ-033 els_p=5, addr=6 -> latch_en_o stays 0, err_o=1 in cycle 2 only, entry_v_o unchanged.
REQ-034 entry_v_o=8'h0F, clear_i pulsed in OPEN of write to addr 5 -> entry_v_o=8'h20.
REQ-035 reset_i asserted in cycle 1 (SETUP) of a write -> latch_en_o never asserts, data_o=0, ready_o=1 after release.
REQ-036 With BSG_DLATCH_WR_PARITY_EN, data=16'h0001 -> data_o=17'h10001; data=16'h0003 -> data_o=17'h00003.
